photonic_xbar_recirc: RTL and testbench
=======================================

# photonic_xbar_recirc

Parametrised successor of the speculative-network photonic switch. It is a synchronous crossbar that models optical time-of-flight and serialisation as pipelined delay lines, and routes each in-flight packet to any egress port and/or an OEO recirculation buffer port. Over the previous switch it adds:
- generic port, buffer-port and data widths;
- per-packet recirculation hop counting with drop-on-limit;
- detection of malformed (multi-hot) configuration rows;
- saturating statistics counters.

It sits between the node ingress links and the egress/OEO buffer banks of the speculative network.

## Interface
Parameters:
- PORTS, 4: ingress/egress port count (≥2).
- BUF_PORTS, 4: OEO buffer ports (1..PORTS).
- WIDTH, 64: packet payload bits, excluding valid.
- TOF, 2: ingress-to-switch flight delay in cycles (≥1).
- SERIAL, 1: switch-to-egress serialisation delay in cycles (≥1).
- RC_W, 2: hop-count field width, held in data[WIDTH-1 -: RC_W].
- MAX_RECIRC, 3: maximum recirculations before drop (≤2^RC_W−1).

Ports (clk and rst_n first):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  switch clock.
  - rst_n  in  1  asynchronous active-low reset.
- Ingress and buffer return:
  - din_valid  in  PORTS  ingress packet valid.
  - din_data  in  PORTS*WIDTH  ingress payloads; port i occupies bits [i*WIDTH +: WIDTH].
  - dfrom_buf_valid  in  BUF_PORTS  buffer-return valid.
  - dfrom_buf_data  in  BUF_PORTS*WIDTH  buffer-return payloads.
- Configuration:
  - cfg  in  PORTS*(PORTS+BUF_PORTS)  per-egress one-hot source select. Bits [0..PORTS-1] select delayed ingress; bits [PORTS..] select buffer returns.
  - cfg_buf  in  BUF_PORTS*PORTS  per-buffer-port one-hot ingress select.
- Request/grant pass-through:
  - req_in / grant_in  in  PORTS*8 each  passed through the flight delay.
  - req_out / grant_out  out  PORTS*8 each  req_in/grant_in delayed TOF cycles.
- Egress and buffer outputs:
  - dout_valid / dout_data  out  PORTS / PORTS*WIDTH  egress outputs.
  - dto_buf_valid / dto_buf_data  out  BUF_PORTS / BUF_PORTS*WIDTH  packets sent to OEO buffers.
- Status:
  - cfg_err  out  1  sticky; set on any multi-hot cfg/cfg_buf row.
  - drop_cnt, err_cnt  out  16 each  saturating counters.

## Operation
- Ingress delay line: din_valid/din_data/req/grant pass through TOF register stages. The stage-TOF output is the "switch input" S_i.
- Buffer returns enter the switch undelayed.
- Egress select: cfg row o is evaluated combinationally against the switch inputs in the same cycle. S_i is aligned with cfg, not with din.
  - One-hot row: egress o takes the selected source's valid and data unchanged.
  - Zero row: egress o is invalid, data 0.
  - Multi-hot row: egress o is invalid, data 0; err_cnt += 1 per offending row per cycle; cfg_err is set.
- Multicast is legal: one source may feed several egress and buffer ports simultaneously.
- Buffer routing: cfg_buf row b one-hot on i, with S_i valid:
  - h = S_i hop field.
  - If h < MAX_RECIRC: dto_buf[b] = S_i with the hop field set to h+1, valid=1.
  - If h ≥ MAX_RECIRC: not forwarded (dto_buf[b] invalid) and drop_cnt += 1.
  - Egress copies of the same packet are not affected by the drop.
  - Multi-hot cfg_buf rows: treated as for egress rows (output invalid, err_cnt += 1, cfg_err set).
- Selecting an invalid source gives an invalid output and no counting.
- Counters:
  - drop_cnt and err_cnt saturate at 16'hFFFF.
  - Several increments in one cycle add as a sum, then saturate.
- cfg_err clears only on reset.

## Timing
- din → dout latency: TOF+SERIAL cycles.
- cfg at cycle t routes S(t) (din from cycle t−TOF). The result appears on dout at t+SERIAL.
- dfrom_buf at cycle t → dout at t+SERIAL.
- dto_buf is registered: it appears at t+1 for cfg_buf at t.
- req_out/grant_out: exactly TOF cycles after req_in/grant_in.
- Counters and cfg_err update at the clock edge after the event cycle.
- Reset (asynchronous, mid-flight allowed) clears immediately:
  - every delay stage to valid=0, data 0;
  - all outputs to 0;
  - counters and cfg_err to 0.
- In-flight packets are lost on reset, with no drop count.
- First valid dout after reset release: no earlier than TOF+SERIAL cycles after the first valid din.

## Test plan
- **Unicast:** PORTS=4, TOF=2, SERIAL=1. din[1] valid, data 0xA5 at t0; cfg row 3 = 0b0000_0010 at t0+2 → dout[3] valid with 0xA5 at t0+3; other egress invalid.
- **Buffer and hop count:** din[0] hop=0 at t0; cfg_buf row 2 selects input 0 at t0+2 → dto_buf[2] valid at t0+3 with hop=1. Return it via dfrom_buf[2]; cfg row 1 bit PORTS+2 → dout[1] at +SERIAL.
- **Drop on limit:** packet with hop=3 (MAX_RECIRC=3) routed to a buffer → dto_buf invalid and drop_cnt=1. A simultaneous egress copy is still delivered.
- **Malformed config:** cfg row 0 = 0b0011 for one cycle → dout[0] invalid, err_cnt=1, cfg_err=1 and remains 1. Rows 0 and 2 multi-hot in the same cycle → err_cnt +2.
- **Reset mid-flight:** rst_n low for one cycle while 3 packets are in the delay lines → all outputs 0 at once; no dout appears afterwards; counters 0.
- **Saturation:** force 70000 multi-hot cycles → err_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/photonic_xbar_recirc_if.sv
// Bundles the data, configuration, pass-through and status signals of the
// photonic crossbar. The master modport is the environment (it drives ingress,
// buffer returns and configuration). The slave modport is the switch itself.
//   din_*, dfrom_buf_*      : ingress packets and OEO buffer returns
//   cfg, cfg_buf            : per-egress / per-buffer-port one-hot source select
//   req_*, grant_*          : request/grant side-band, delayed by flight time
//   dout_*, dto_buf_*       : egress packets and packets sent to the OEO buffers
//   cfg_err, drop_cnt, err_cnt : status
interface photonic_xbar_recirc_if #(
  parameter int PORTS     = 4,
  parameter int BUF_PORTS = 4,
  parameter int WIDTH     = 64
);
  logic [PORTS-1:0]                   din_valid;
  logic [PORTS*WIDTH-1:0]             din_data;
  logic [BUF_PORTS-1:0]               dfrom_buf_valid;
  logic [BUF_PORTS*WIDTH-1:0]         dfrom_buf_data;
  logic [PORTS*(PORTS+BUF_PORTS)-1:0] cfg;
  logic [BUF_PORTS*PORTS-1:0]         cfg_buf;
  logic [PORTS*8-1:0]                 req_in;
  logic [PORTS*8-1:0]                 grant_in;
  logic [PORTS*8-1:0]                 req_out;
  logic [PORTS*8-1:0]                 grant_out;
  logic [PORTS-1:0]                   dout_valid;
  logic [PORTS*WIDTH-1:0]             dout_data;
  logic [BUF_PORTS-1:0]               dto_buf_valid;
  logic [BUF_PORTS*WIDTH-1:0]         dto_buf_data;
  logic                               cfg_err;
  logic [15:0]                        drop_cnt;
  logic [15:0]                        err_cnt;

  modport master (
    output din_valid, din_data, dfrom_buf_valid, dfrom_buf_data,
           cfg, cfg_buf, req_in, grant_in,
    input  req_out, grant_out, dout_valid, dout_data,
           dto_buf_valid, dto_buf_data, cfg_err, drop_cnt, err_cnt
  );

  modport slave (
    input  din_valid, din_data, dfrom_buf_valid, dfrom_buf_data,
           cfg, cfg_buf, req_in, grant_in,
    output req_out, grant_out, dout_valid, dout_data,
           dto_buf_valid, dto_buf_data, cfg_err, drop_cnt, err_cnt
  );
endinterface

// File: rtl/photonic_xbar_recirc.sv
// Synchronous photonic crossbar with OEO recirculation. Ingress packets fly
// through a TOF-stage delay line to the switch inputs S_i. Each egress picks one
// switch input or buffer return (one-hot cfg row) and serialises it through
// SERIAL register stages. Each buffer port picks one switch input (one-hot
// cfg_buf row), bumps its hop count and forwards it, or drops it once the hop
// limit is reached. Multi-hot rows give no output, count in err_cnt and set the
// sticky cfg_err flag.
//   clk, rst_n : switch clock, asynchronous active-low reset
//   bus        : slave side of photonic_xbar_recirc_if (all data/cfg/status)
module photonic_xbar_recirc #(
  parameter int PORTS      = 4,
  parameter int BUF_PORTS  = 4,
  parameter int WIDTH      = 64,
  parameter int TOF        = 2,
  parameter int SERIAL     = 1,
  parameter int RC_W       = 2,
  parameter int MAX_RECIRC = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  photonic_xbar_recirc_if.slave bus
);
  localparam int SRC = PORTS + BUF_PORTS;

  logic [PORTS-1:0]       r_dl_v   [TOF];
  logic [PORTS*WIDTH-1:0] r_dl_d   [TOF];
  logic [PORTS*8-1:0]     r_dl_req [TOF];
  logic [PORTS*8-1:0]     r_dl_gnt [TOF];

  logic [PORTS-1:0]       r_ser_v [SERIAL];
  logic [PORTS*WIDTH-1:0] r_ser_d [SERIAL];

  logic [BUF_PORTS-1:0]       r_tb_v;
  logic [BUF_PORTS*WIDTH-1:0] r_tb_d;
  logic [15:0]                r_drop_cnt;
  logic [15:0]                r_err_cnt;
  logic                       r_cfg_err;

  logic                       w_src_v [SRC];
  logic [WIDTH-1:0]           w_src_d [SRC];
  logic [PORTS-1:0]           w_eg_v;
  logic [PORTS*WIDTH-1:0]     w_eg_d;
  logic [BUF_PORTS-1:0]       w_tb_v;
  logic [BUF_PORTS*WIDTH-1:0] w_tb_d;
  logic [SRC-1:0]             w_row;
  logic [PORTS-1:0]           w_brow;
  logic [RC_W-1:0]            w_hop;
  logic [15:0]                w_err_inc;
  logic [15:0]                w_drop_inc;
  logic [16:0]                w_err_sum;
  logic [16:0]                w_drop_sum;

  // Flight delay line; the last stage is the switch input S_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TOF; k++) begin
        r_dl_v[k]   <= '0;
        r_dl_d[k]   <= '0;
        r_dl_req[k] <= '0;
        r_dl_gnt[k] <= '0;
      end
    end else begin
      r_dl_v[0]   <= bus.din_valid;
      r_dl_d[0]   <= bus.din_data;
      r_dl_req[0] <= bus.req_in;
      r_dl_gnt[0] <= bus.grant_in;
      for (int k = 1; k < TOF; k++) begin
        r_dl_v[k]   <= r_dl_v[k-1];
        r_dl_d[k]   <= r_dl_d[k-1];
        r_dl_req[k] <= r_dl_req[k-1];
        r_dl_gnt[k] <= r_dl_gnt[k-1];
      end
    end
  end

  // Source table: delayed ingress first, undelayed buffer returns after.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      w_src_v[i] = r_dl_v[TOF-1][i];
      w_src_d[i] = r_dl_d[TOF-1][i*WIDTH +: WIDTH];
    end
    for (int b = 0; b < BUF_PORTS; b++) begin
      w_src_v[PORTS+b] = bus.dfrom_buf_valid[b];
      w_src_d[PORTS+b] = bus.dfrom_buf_data[b*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_eg_v     = '0;
    w_eg_d     = '0;
    w_tb_v     = '0;
    w_tb_d     = '0;
    w_row      = '0;
    w_brow     = '0;
    w_hop      = '0;
    w_err_inc  = '0;
    w_drop_inc = '0;

    for (int o = 0; o < PORTS; o++) begin
      w_row = bus.cfg[o*SRC +: SRC];
      // x & (x-1) is non-zero exactly when more than one bit is set.
      if ((w_row & (w_row - 1'b1)) != '0) begin
        w_err_inc = w_err_inc + 16'd1;
      end else begin
        for (int s = 0; s < SRC; s++) begin
          if (w_row[s]) begin
            w_eg_v[o]                 = w_src_v[s];
            w_eg_d[o*WIDTH +: WIDTH]  = w_src_d[s];
          end
        end
      end
    end

    for (int b = 0; b < BUF_PORTS; b++) begin
      w_brow = bus.cfg_buf[b*PORTS +: PORTS];
      if ((w_brow & (w_brow - 1'b1)) != '0) begin
        w_err_inc = w_err_inc + 16'd1;
      end else begin
        for (int i = 0; i < PORTS; i++) begin
          if (w_brow[i] && w_src_v[i]) begin
            w_hop = w_src_d[i][WIDTH-1 -: RC_W];
            if (w_hop < RC_W'(MAX_RECIRC)) begin
              w_tb_v[b]                = 1'b1;
              w_tb_d[b*WIDTH +: WIDTH] = {RC_W'(w_hop + 1'b1),
                                          w_src_d[i][WIDTH-RC_W-1:0]};
            end else begin
              w_drop_inc = w_drop_inc + 16'd1;
            end
          end
        end
      end
    end
  end

  // Per-cycle increments are summed first, then clamped at all-ones.
  assign w_err_sum  = {1'b0, r_err_cnt}  + {1'b0, w_err_inc};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SERIAL; k++) begin
        r_ser_v[k] <= '0;
        r_ser_d[k] <= '0;
      end
      r_tb_v     <= '0;
      r_tb_d     <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_ser_v[0] <= w_eg_v;
      r_ser_d[0] <= w_eg_d;
      for (int k = 1; k < SERIAL; k++) begin
        r_ser_v[k] <= r_ser_v[k-1];
        r_ser_d[k] <= r_ser_d[k-1];
      end
      r_tb_v     <= w_tb_v;
      r_tb_d     <= w_tb_d;
      r_err_cnt  <= w_err_sum[16]  ? 16'hFFFF : w_err_sum[15:0];
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_cfg_err  <= r_cfg_err | (w_err_inc != '0);
    end
  end

  assign bus.req_out       = r_dl_req[TOF-1];
  assign bus.grant_out     = r_dl_gnt[TOF-1];
  assign bus.dout_valid    = r_ser_v[SERIAL-1];
  assign bus.dout_data     = r_ser_d[SERIAL-1];
  assign bus.dto_buf_valid = r_tb_v;
  assign bus.dto_buf_data  = r_tb_d;
  assign bus.cfg_err       = r_cfg_err;
  assign bus.drop_cnt      = r_drop_cnt;
  assign bus.err_cnt       = r_err_cnt;
endmodule

// File: tb/tb_photonic_xbar_recirc.sv
module tb_photonic_xbar_recirc;
  localparam int PORTS = 4;
  localparam int BUFP  = 4;
  localparam int W     = 64;
  localparam int SRC   = PORTS + BUFP;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n_fail;

  photonic_xbar_recirc_if #(.PORTS(PORTS), .BUF_PORTS(BUFP), .WIDTH(W)) bus ();

  photonic_xbar_recirc #(
    .PORTS(PORTS), .BUF_PORTS(BUFP), .WIDTH(W), .TOF(2), .SERIAL(1),
    .RC_W(2), .MAX_RECIRC(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.din_valid       = '0;
    bus.din_data        = '0;
    bus.dfrom_buf_valid = '0;
    bus.dfrom_buf_data  = '0;
    bus.cfg             = '0;
    bus.cfg_buf         = '0;
    bus.req_in          = '0;
    bus.grant_in        = '0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_dout_valid", 64'(bus.dout_valid), 64'h0);
    chk("reset_err_cnt", 64'(bus.err_cnt), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Unicast: din[1]=0xA5 at c0, cfg row 3 selects input 1 at c0+2.
    bus.din_valid[1]          = 1'b1;
    bus.din_data[1*W +: W]    = 64'hA5;
    bus.req_in                = 32'hDEADBEEF;
    bus.grant_in              = 32'h12345678;
    step();
    bus.din_valid             = '0;
    bus.din_data              = '0;
    bus.req_in                = '0;
    bus.grant_in              = '0;
    chk("req_out_early", 64'(bus.req_out), 64'h0);
    step();
    chk("req_out_tof", 64'(bus.req_out), 64'hDEADBEEF);
    chk("grant_out_tof", 64'(bus.grant_out), 64'h12345678);
    bus.cfg[3*SRC +: SRC]     = 8'b0000_0010;
    step();
    chk("unicast_valid", 64'(bus.dout_valid), 64'h8);
    chk("unicast_data", bus.dout_data[3*W +: W], 64'hA5);
    chk("unicast_other_data", bus.dout_data[1*W +: W], 64'h0);
    bus.cfg                   = '0;
    step();
    chk("unicast_gone", 64'(bus.dout_valid), 64'h0);

    // Buffer routing with hop increment, then return through buffer 2.
    bus.din_valid[0]          = 1'b1;
    bus.din_data[0*W +: W]    = 64'h0000_0000_0000_0123;
    step();
    clear_inputs();
    step();
    bus.cfg_buf[2*PORTS +: PORTS] = 4'b0001;
    step();
    chk("tobuf_valid", 64'(bus.dto_buf_valid), 64'h4);
    chk("tobuf_hop1", bus.dto_buf_data[2*W +: W], 64'h4000_0000_0000_0123);
    chk("tobuf_no_egress", 64'(bus.dout_valid), 64'h0);
    clear_inputs();
    bus.dfrom_buf_valid[2]       = 1'b1;
    bus.dfrom_buf_data[2*W +: W] = 64'h4000_0000_0000_0123;
    bus.cfg[1*SRC +: SRC]        = 8'b0100_0000;
    step();
    chk("return_valid", 64'(bus.dout_valid), 64'h2);
    chk("return_data", bus.dout_data[1*W +: W], 64'h4000_0000_0000_0123);
    chk("return_tobuf_idle", 64'(bus.dto_buf_valid), 64'h0);
    clear_inputs();

    // Hop limit reached: buffer copy dropped, egress copy delivered.
    bus.din_valid[2]          = 1'b1;
    bus.din_data[2*W +: W]    = 64'hC000_0000_0000_0077;
    step();
    clear_inputs();
    step();
    bus.cfg_buf[0*PORTS +: PORTS] = 4'b0100;
    bus.cfg[0*SRC +: SRC]         = 8'b0000_0100;
    step();
    chk("drop_tobuf_invalid", 64'(bus.dto_buf_valid), 64'h0);
    chk("drop_egress_valid", 64'(bus.dout_valid), 64'h1);
    chk("drop_egress_data", bus.dout_data[0*W +: W], 64'hC000_0000_0000_0077);
    chk("drop_cnt_1", 64'(bus.drop_cnt), 64'h1);
    chk("drop_no_err", 64'(bus.err_cnt), 64'h0);
    chk("drop_cfg_err_clear", 64'(bus.cfg_err), 64'h0);
    step();
    chk("drop_invalid_src_nocount", 64'(bus.drop_cnt), 64'h1);
    clear_inputs();

    // Malformed rows.
    bus.cfg[0*SRC +: SRC]     = 8'b0000_0011;
    step();
    chk("mh_dout0_invalid", 64'(bus.dout_valid), 64'h0);
    chk("mh_err_cnt_1", 64'(bus.err_cnt), 64'h1);
    chk("mh_cfg_err_set", 64'(bus.cfg_err), 64'h1);
    clear_inputs();
    step();
    chk("mh_cfg_err_sticky", 64'(bus.cfg_err), 64'h1);
    chk("mh_err_cnt_hold", 64'(bus.err_cnt), 64'h1);
    bus.cfg[0*SRC +: SRC]     = 8'b1000_0001;
    bus.cfg[2*SRC +: SRC]     = 8'b0001_1000;
    step();
    chk("mh_two_rows", 64'(bus.err_cnt), 64'h3);
    clear_inputs();
    bus.cfg_buf[1*PORTS +: PORTS] = 4'b0011;
    step();
    chk("mh_buf_row", 64'(bus.err_cnt), 64'h4);
    chk("mh_buf_row_invalid", 64'(bus.dto_buf_valid), 64'h0);
    clear_inputs();
    step();

    // Reset with packets in flight.
    bus.cfg[0*SRC +: SRC]     = 8'b0000_0001;
    for (int k = 1; k <= 3; k++) begin
      bus.din_valid[0]        = 1'b1;
      bus.din_data[0*W +: W]  = 64'(k);
      bus.req_in              = 32'hA5A5A5A5;
      step();
    end
    bus.din_valid = '0;
    bus.din_data  = '0;
    chk("pre_reset_dout", 64'(bus.dout_valid), 64'h1);
    chk("pre_reset_data", bus.dout_data[0*W +: W], 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'h0);
    chk("rst_dout_data", bus.dout_data[0*W +: W], 64'h0);
    chk("rst_req_out", 64'(bus.req_out), 64'h0);
    chk("rst_err_cnt", 64'(bus.err_cnt), 64'h0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'h0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'h0);
    bus.req_in = '0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_no_dout", 64'(bus.dout_valid), 64'h0);
    end
    clear_inputs();

    // Saturation: all 8 rows multi-hot, 8 increments per cycle.
    for (int o = 0; o < PORTS; o++) bus.cfg[o*SRC +: SRC] = 8'hFF;
    for (int b = 0; b < BUFP; b++) bus.cfg_buf[b*PORTS +: PORTS] = 4'hF;
    step();
    chk("sat_first_cycle", 64'(bus.err_cnt), 64'h8);
    for (int k = 0; k < 8200; k++) step();
    chk("sat_err_cnt", 64'(bus.err_cnt), 64'hFFFF);
    step();
    chk("sat_err_cnt_hold", 64'(bus.err_cnt), 64'hFFFF);
    chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'h0);
    chk("sat_cfg_err", 64'(bus.cfg_err), 64'h1);
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
